// File: rtl/usb_host_token_tx.sv
// usb_host_token_tx
//
// Host-side full-speed USB token transmitter. Serialises one token packet
// (OUT, IN, SETUP or SOF) per request onto the differential pins, one bit
// per clk12_i cycle:
//   SYNC -> PID byte -> 11-bit payload -> CRC5 -> EOP (SE0 x N, then J)
// Bits are NRZI encoded (0 toggles the line, 1 holds it). A zero is stuffed
// after every six consecutive ones from the SYNC final bit through the last
// CRC bit.
//
// Ports:
//   clk12_i           12 MHz bit clock
//   rst_n_i           asynchronous active-low reset
//   txReqSendToken_i  send request, sampled only while idle
//   pid_i             PID nibble; byte on the wire is {~pid_i, pid_i}
//   addr_i, endp_i    token address / endpoint
//   frameNum_i        SOF frame number (payload when pid_i == SOF)
//   busy_o            packet in progress
//   done_o            one-cycle pulse after the EOP J bit
//   dataOutEn_o       pin drive enable
//   dataOutP_o        DP value
//   dataOutN_o        DN value
//
// Optional build macro USB_HOST_TX_HANDSHAKE_EN: when defined, PIDs with
// pid_i[1:0] == 2'b10 (handshakes) are sent as PID-only packets with no
// payload and no CRC.

module usb_host_token_tx #(
  parameter int SYNC_BITS    = 8,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic        clk12_i,
  input  logic        rst_n_i,
  input  logic        txReqSendToken_i,
  input  logic [3:0]  pid_i,
  input  logic [6:0]  addr_i,
  input  logic [3:0]  endp_i,
  input  logic [10:0] frameNum_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        dataOutEn_o,
  output logic        dataOutP_o,
  output logic        dataOutN_o
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PID,
    DATA,
    CRC,
    EOP_SE0,
    EOP_J
  } stateT;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_BITS - 1);
  localparam logic [3:0] SE0_LAST  = 4'(EOP_SE0_BITS - 1);
  localparam logic [3:0] PID_SOF   = 4'b0101;

  stateT       state;
  stateT       nextState;
  logic [3:0]  bitCnt;
  logic [3:0]  nextCnt;
  logic        stuffNow;
  logic        nextBit;
  logic        nextIsField;
  logic [2:0]  onesCnt;
  logic        lineJ;
  logic [3:0]  pidReg;
  logic [10:0] payloadReg;
  logic [4:0]  crcReg;
  logic [4:0]  crcNext;
  logic        crcFb;
  logic [2:0]  crcIdx;
  logic        doneReg;
  logic        accept;
  logic [7:0]  pidByte;

  assign accept  = (state == IDLE) && txReqSendToken_i;
  assign pidByte = {~pidReg, pidReg};

  // state and bitCnt always describe the bit currently on the pins; a
  // stuffed bit reuses the position of the real bit just before it, so the
  // normal advance after the stuff lands on the correct next field bit.
  always_ff @(posedge clk12_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      bitCnt <= '0;
    end else begin
      state  <= nextState;
      bitCnt <= nextCnt;
    end
  end

  // Next-position logic: either hold position for a stuffed bit, or step to
  // the following bit of the packet.
  always_comb begin
    stuffNow  = 1'b0;
    nextState = state;
    nextCnt   = bitCnt + 4'd1;
    if ((state inside {SYNC, PID, DATA, CRC}) && (onesCnt == 3'd6)) begin
      stuffNow = 1'b1;
      nextCnt  = bitCnt;
    end else begin
      case (state)
        IDLE: begin
          nextCnt = '0;
          if (txReqSendToken_i) nextState = SYNC;
        end
        SYNC: begin
          if (bitCnt == SYNC_LAST) begin
            nextState = PID;
            nextCnt   = '0;
          end
        end
        PID: begin
          if (bitCnt == 4'd7) begin
            nextCnt = '0;
`ifdef USB_HOST_TX_HANDSHAKE_EN
            if (pidReg[1:0] == 2'b10) nextState = EOP_SE0;
            else                      nextState = DATA;
`else
            nextState = DATA;
`endif
          end
        end
        DATA: begin
          if (bitCnt == 4'd10) begin
            nextState = CRC;
            nextCnt   = '0;
          end
        end
        CRC: begin
          if (bitCnt == 4'd4) begin
            nextState = EOP_SE0;
            nextCnt   = '0;
          end
        end
        EOP_SE0: begin
          if (bitCnt == SE0_LAST) begin
            nextState = EOP_J;
            nextCnt   = '0;
          end
        end
        EOP_J: begin
          nextState = IDLE;
          nextCnt   = '0;
        end
        default: begin
          nextState = IDLE;
          nextCnt   = '0;
        end
      endcase
    end
  end

  // Logical value of the bit about to be loaded, and the CRC after
  // absorbing it. The CRC goes out complemented, crc[4] first.
  always_comb begin
    nextIsField = nextState inside {SYNC, PID, DATA, CRC};
    crcIdx      = 3'd4 - nextCnt[2:0];
    case (nextState)
      SYNC:    nextBit = (nextCnt == SYNC_LAST);
      PID:     nextBit = pidByte[nextCnt[2:0]];
      DATA:    nextBit = payloadReg[nextCnt];
      CRC:     nextBit = ~crcReg[crcIdx];
      default: nextBit = 1'b1;
    endcase
    crcFb   = crcReg[4] ^ nextBit;
    crcNext = {crcReg[3:0], 1'b0} ^ (crcFb ? 5'b00101 : 5'b00000);
  end

  // Datapath: field latching, CRC, NRZI line level and the ones run counter.
  // Outside the SYNC..CRC fields the line rests at J and the run clears.
  always_ff @(posedge clk12_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pidReg     <= '0;
      payloadReg <= '0;
      crcReg     <= 5'b11111;
      lineJ      <= 1'b1;
      onesCnt    <= '0;
      doneReg    <= 1'b0;
    end else begin
      doneReg <= (state == EOP_J);
      if (accept) begin
        pidReg     <= pid_i;
        payloadReg <= (pid_i == PID_SOF) ? frameNum_i : {endp_i, addr_i};
        crcReg     <= 5'b11111;
      end else if (!stuffNow && (nextState == DATA)) begin
        crcReg <= crcNext;
      end
      if (stuffNow) begin
        lineJ   <= ~lineJ;
        onesCnt <= '0;
      end else if (nextIsField) begin
        lineJ   <= nextBit ? lineJ : ~lineJ;
        onesCnt <= nextBit ? onesCnt + 3'd1 : 3'd0;
      end else begin
        lineJ   <= 1'b1;
        onesCnt <= '0;
      end
    end
  end

  // Pins come straight from registered state, so reset drops the drive
  // enable immediately rather than at the next edge.
  always_comb begin
    busy_o      = (state != IDLE);
    done_o      = doneReg;
    dataOutEn_o = (state != IDLE);
    dataOutP_o  = (state == EOP_SE0) ? 1'b0 : lineJ;
    dataOutN_o  = (state == EOP_SE0) ? 1'b0 : ~lineJ;
  end

endmodule

// File: tb/tb_usb_host_token_tx.sv
// tb_usb_host_token_tx
//
// Scoreboard bench for usb_host_token_tx. Each issued packet pushes its
// expected fields (hand-computed CRC5 field and stuff count) into sbQ; a
// monitor captures every driven burst, NRZI-decodes and unstuffs it, and
// compares against the popped entry.

module tb_usb_host_token_tx;

  logic        clk12_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        txReq = 1'b0;
  logic [3:0]  pid = '0;
  logic [6:0]  addr = '0;
  logic [3:0]  endp = '0;
  logic [10:0] frame = '0;
  logic        busy_o;
  logic        done_o;
  logic        dataOutEn_o;
  logic        dataOutP_o;
  logic        dataOutN_o;

  usb_host_token_tx #(.SYNC_BITS(8), .EOP_SE0_BITS(2)) dut (
    .clk12_i          (clk12_i),
    .rst_n_i          (rst_n_i),
    .txReqSendToken_i (txReq),
    .pid_i            (pid),
    .addr_i           (addr),
    .endp_i           (endp),
    .frameNum_i       (frame),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .dataOutEn_o      (dataOutEn_o),
    .dataOutP_o       (dataOutP_o),
    .dataOutN_o       (dataOutN_o)
  );

  always #5 clk12_i = ~clk12_i;

  typedef struct {
    string      name;
    logic [7:0] pidByte;
    logic [10:0] payload;
    logic [4:0] crcField;
    int         stuffs;
    int         driven;
    bit         pidOnly;
    bit         abort;
  } expT;

  expT        sbQ[$];
  logic [1:0] line[$];
  int         assertCount = 0;
  int         failCount = 0;
  int         pktPushed = 0;
  int         pktSeen = 0;
  int         spuriousDone = 0;
  int         idleRun = 0;
  int         lastGap = 0;
  bit         capturing = 1'b0;

  // Single comparison point; every check funnels through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Serial CRC5 (x^5+x^2+1, preset ones) over bits[first +: count].
  function automatic logic [4:0] crcOver(input logic [31:0] bits, input int first,
                                         input int count);
    logic [4:0] r;
    logic       fb;
    r = 5'b11111;
    for (int k = 0; k < count; k++) begin
      fb = r[4] ^ bits[first + k];
      r  = {r[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    return r;
  endfunction

  function automatic expT makeExp(input string name, input logic [3:0] p,
                                  input logic [6:0] a, input logic [3:0] e,
                                  input logic [10:0] f, input logic [4:0] crcField,
                                  input int stuffs, input bit abort);
    expT x;
    x.name     = name;
    x.pidByte  = {~p, p};
    x.payload  = (p == 4'b0101) ? f : {e, a};
    x.crcField = crcField;
    x.stuffs   = stuffs;
    x.abort    = abort;
`ifdef USB_HOST_TX_HANDSHAKE_EN
    x.pidOnly  = (p[1:0] == 2'b10);
`else
    x.pidOnly  = 1'b0;
`endif
    x.driven   = x.pidOnly ? 19 : 35 + stuffs;
    return x;
  endfunction

  // Decode one captured burst and compare with the next scoreboard entry.
  task automatic finishPacket();
    expT         e;
    logic [31:0] bits;
    int          n, nBits, stuffs, ones, badStuff;
    logic        prev, lvl, raw;
    logic [4:0]  crcV;
    pktSeen++;
    checkOutput("done_o in cycle after EOP_J", done_o, 1);
    checkOutput("packet expected by scoreboard", (sbQ.size() > 0), 1);
    if (sbQ.size() == 0) return;
    e = sbQ.pop_front();
    checkOutput({e.name, " completed (abort expected?)"}, e.abort, 0);
    n = line.size();
    checkOutput({e.name, " driven cycles"}, n, e.driven);
    if (n < 3) return;
    checkOutput({e.name, " EOP SE0,SE0,J"}, {line[n-3], line[n-2], line[n-1]}, 6'b000010);
    bits = '0; nBits = 0; stuffs = 0; ones = 0; badStuff = 0; prev = 1'b1;
    for (int i = 0; i < n - 3; i++) begin
      lvl  = (line[i] == 2'b10);
      raw  = (lvl == prev);
      prev = lvl;
      if (ones == 6) begin
        stuffs++;
        ones = 0;
        if (raw) badStuff++;
      end else begin
        if (nBits < 32) bits[nBits] = raw;
        nBits++;
        ones = raw ? ones + 1 : 0;
      end
    end
    checkOutput({e.name, " stuffed bits"}, stuffs, e.stuffs);
    checkOutput({e.name, " stuffed bits are zeros"}, badStuff, 0);
    checkOutput({e.name, " unstuffed bit count"}, nBits, e.pidOnly ? 16 : 32);
    checkOutput({e.name, " SYNC"}, bits[7:0], 8'h80);
    checkOutput({e.name, " PID byte"}, bits[15:8], e.pidByte);
    if (!e.pidOnly) begin
      for (int k = 0; k < 5; k++) crcV[4-k] = bits[27+k];
      checkOutput({e.name, " payload"}, bits[26:16], e.payload);
      checkOutput({e.name, " CRC5 field"}, crcV, e.crcField);
      checkOutput({e.name, " CRC5 residual"}, crcOver(bits, 16, 16), 5'b01100);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    expT e;
    forever begin
      @(negedge clk12_i);
      if (!rst_n_i) begin
        if (capturing) begin
          capturing = 1'b0;
          line.delete();
          checkOutput("aborted packet expected by scoreboard", (sbQ.size() > 0), 1);
          if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput({e.name, " aborted by reset"}, e.abort, 1);
          end
        end
        idleRun = 0;
      end else if (dataOutEn_o) begin
        if (!capturing) begin
          capturing = 1'b1;
          line.delete();
          lastGap = idleRun;
        end
        line.push_back({dataOutP_o, dataOutN_o});
        if (done_o) spuriousDone++;
      end else if (capturing) begin
        capturing = 1'b0;
        finishPacket();
        idleRun = 1;
      end else begin
        idleRun++;
        if (done_o) spuriousDone++;
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [3:0] p,
                               input logic [6:0] a, input logic [3:0] e,
                               input logic [10:0] f, input logic [4:0] crcField,
                               input int stuffs);
    sbQ.push_back(makeExp(name, p, a, e, f, crcField, stuffs, 1'b0));
    pktPushed++;
    @(negedge clk12_i);
    pid = p; addr = a; endp = e; frame = f; txReq = 1'b1;
    @(negedge clk12_i);
    txReq = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk12_i);
      #1;
      if (!busy_o && !capturing && sbQ.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput({name, " finished within budget"}, ok, 1);
  endtask

  initial begin
    int enSeen, doneSeen;
    bit sawDone;

    // Reset and idle behaviour.
    #12;
    checkOutput("reset dataOutEn_o", dataOutEn_o, 0);
    checkOutput("reset P/N is J", {dataOutP_o, dataOutN_o}, 2'b10);
    checkOutput("reset busy_o", busy_o, 0);
    checkOutput("reset done_o", done_o, 0);
    @(negedge clk12_i);
    rst_n_i = 1'b1;
    enSeen = 0; doneSeen = 0;
    repeat (100) begin
      @(negedge clk12_i);
      if (dataOutEn_o) enSeen++;
      if (done_o) doneSeen++;
    end
    checkOutput("idle: no drive over 100 cycles", enSeen, 0);
    checkOutput("idle: no done over 100 cycles", doneSeen, 0);
    checkOutput("idle: P/N is J", {dataOutP_o, dataOutN_o}, 2'b10);
    checkOutput("idle: busy_o", busy_o, 0);

    // Directed vectors: name, pid, addr, endp, frame, CRC5 field, stuffs.
    applyStimulus("OUT 15/E", 4'b0001, 7'h15, 4'hE, 11'h000, 5'b10111, 0);
    waitIdle("OUT 15/E", 200);
    applyStimulus("OUT 7F/F", 4'b0001, 7'h7F, 4'hF, 11'h000, 5'b00010, 2);
    waitIdle("OUT 7F/F", 200);
    applyStimulus("SOF 7FF", 4'b0101, 7'h15, 4'hE, 11'h7FF, 5'b00010, 2);
    waitIdle("SOF 7FF", 200);
    applyStimulus("SOF 000", 4'b0101, 7'h7F, 4'hF, 11'h000, 5'b01000, 0);
    waitIdle("SOF 000", 200);
    applyStimulus("SETUP 0/0", 4'b1101, 7'h00, 4'h0, 11'h5A5, 5'b01000, 0);
    waitIdle("SETUP 0/0", 200);
    applyStimulus("ACK", 4'b0010, 7'h00, 4'h0, 11'h000, 5'b01000, 0);
    waitIdle("ACK", 200);

    // Request while busy must be ignored.
    applyStimulus("OUT during-busy", 4'b0001, 7'h15, 4'hE, 11'h000, 5'b10111, 0);
    repeat (5) @(negedge clk12_i);
    pid = 4'b1101; addr = 7'h33; endp = 4'h2; txReq = 1'b1;
    repeat (3) @(negedge clk12_i);
    txReq = 1'b0;
    waitIdle("OUT during-busy", 200);
    repeat (5) @(negedge clk12_i);
    checkOutput("busy request ignored: packets seen", pktSeen, pktPushed);

    // Back-to-back: request held through the done_o cycle.
    sbQ.push_back(makeExp("IN 15/E b2b", 4'b1001, 7'h15, 4'hE, 11'h000, 5'b10111, 0, 1'b0));
    sbQ.push_back(makeExp("SETUP 0/0 b2b", 4'b1101, 7'h00, 4'h0, 11'h000, 5'b01000, 0, 1'b0));
    pktPushed += 2;
    @(negedge clk12_i);
    pid = 4'b1001; addr = 7'h15; endp = 4'hE; txReq = 1'b1;
    @(negedge clk12_i);
    pid = 4'b1101; addr = 7'h00; endp = 4'h0;
    sawDone = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk12_i);
      if (done_o) begin
        sawDone = 1'b1;
        break;
      end
    end
    checkOutput("b2b: first packet done", sawDone, 1);
    @(negedge clk12_i);
    txReq = 1'b0;
    waitIdle("b2b", 200);
    checkOutput("b2b: idle gap cycles", lastGap, 1);

    // Reset about ten cycles into a packet.
    sbQ.push_back(makeExp("OUT aborted", 4'b0001, 7'h15, 4'hE, 11'h000, 5'b10111, 0, 1'b1));
    @(negedge clk12_i);
    pid = 4'b0001; addr = 7'h15; endp = 4'hE; txReq = 1'b1;
    @(negedge clk12_i);
    txReq = 1'b0;
    repeat (9) @(posedge clk12_i);
    #1;
    checkOutput("abort: driving before reset", dataOutEn_o, 1);
    #1;
    rst_n_i = 1'b0;
    #1;
    checkOutput("abort: drive enable drops at once", dataOutEn_o, 0);
    checkOutput("abort: P/N is J", {dataOutP_o, dataOutN_o}, 2'b10);
    checkOutput("abort: busy_o", busy_o, 0);
    repeat (3) @(negedge clk12_i);
    #1;
    checkOutput("abort: scoreboard drained", sbQ.size(), 0);
    rst_n_i = 1'b1;
    enSeen = 0; doneSeen = 0;
    repeat (20) begin
      @(negedge clk12_i);
      if (dataOutEn_o) enSeen++;
      if (done_o) doneSeen++;
    end
    checkOutput("abort: no EOP after reset", enSeen, 0);
    checkOutput("abort: no done after reset", doneSeen, 0);

    checkOutput("total packets seen", pktSeen, pktPushed);
    checkOutput("spurious done_o pulses", spuriousDone, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
